exwb_skid_reg: RTL

//  Parametrised EX->WB stage register with valid/ready flow control, flush and
//  an optional one-entry skid buffer that breaks the combinational ready path.

---
 rtl/exwb_skid_reg.sv | 128 ++++++++++++
 1 files changed

// File: rtl/exwb_skid_reg.sv
// EX->WB stage register with valid/ready handshake, flush, optional one-entry
// skid buffer (registered in_ready) and WB-stage bypass hit flags.
module exwb_skid_reg #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_result,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  input  logic [RD_W-1:0]   rs1_idx,
  input  logic [RD_W-1:0]   rs2_idx,
  output logic              byp_rs1_hit,
  output logic              byp_rs2_hit
);

  logic              main_valid, main_rw;
  logic [DATA_W-1:0] main_result;
  logic [RD_W-1:0]   main_rd;
  logic              skid_valid, skid_rw;
  logic [DATA_W-1:0] skid_result;
  logic [RD_W-1:0]   skid_rd;
  logic              in_ready_q;

  logic              main_valid_nxt, main_rw_nxt;
  logic [DATA_W-1:0] main_result_nxt;
  logic [RD_W-1:0]   main_rd_nxt;
  logic              skid_valid_nxt, skid_rw_nxt;
  logic [DATA_W-1:0] skid_result_nxt;
  logic [RD_W-1:0]   skid_rd_nxt;

  logic main_free, accept, in_rw_qual;

  // With SKID_EN=0 an accept only happens when main is free, so the skid
  // path below is never taken and the skid flops reduce to constants.
  always_comb begin
    main_free  = !main_valid | out_ready;
    in_ready   = (SKID_EN != 0) ? (in_ready_q & !reset) : (main_free & !reset);
    accept     = in_valid & in_ready;
    in_rw_qual = in_reg_write & (in_rd != '0);

    main_valid_nxt  = main_valid;
    main_rw_nxt     = main_rw;
    main_result_nxt = main_result;
    main_rd_nxt     = main_rd;
    skid_valid_nxt  = skid_valid;
    skid_rw_nxt     = skid_rw;
    skid_result_nxt = skid_result;
    skid_rd_nxt     = skid_rd;

    if (main_free) begin
      if (skid_valid) begin
        main_valid_nxt  = 1'b1;
        main_rw_nxt     = skid_rw;
        main_result_nxt = skid_result;
        main_rd_nxt     = skid_rd;
        skid_valid_nxt  = accept;
        if (accept) begin
          skid_rw_nxt     = in_rw_qual;
          skid_result_nxt = in_result;
          skid_rd_nxt     = in_rd;
        end
      end else begin
        main_valid_nxt = accept;
        if (accept) begin
          main_rw_nxt     = in_rw_qual;
          main_result_nxt = in_result;
          main_rd_nxt     = in_rd;
        end
      end
    end else if (accept) begin
      skid_valid_nxt  = 1'b1;
      skid_rw_nxt     = in_rw_qual;
      skid_result_nxt = in_result;
      skid_rd_nxt     = in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid  <= 1'b0;
      main_rw     <= 1'b0;
      main_result <= '0;
      main_rd     <= '0;
      skid_valid  <= 1'b0;
      skid_rw     <= 1'b0;
      skid_result <= '0;
      skid_rd     <= '0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_rw    <= 1'b0;
      skid_valid <= 1'b0;
      skid_rw    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid  <= main_valid_nxt;
      main_rw     <= main_rw_nxt;
      main_result <= main_result_nxt;
      main_rd     <= main_rd_nxt;
      skid_valid  <= skid_valid_nxt;
      skid_rw     <= skid_rw_nxt;
      skid_result <= skid_result_nxt;
      skid_rd     <= skid_rd_nxt;
      in_ready_q  <= !skid_valid_nxt;
    end
  end

  always_comb begin
    out_valid     = main_valid;
    out_reg_write = main_valid & main_rw;
    out_result    = main_result;
    out_rd        = main_rd;
    byp_rs1_hit   = out_reg_write & (main_rd == rs1_idx);
    byp_rs2_hit   = out_reg_write & (main_rd == rs2_idx);
  end

endmodule
